// File: rtl/ifetch_unit.sv
// Instruction fetch unit: program-loadable instruction memory plus a PC that
// runs (with stall, branch redirect and halt detection) ahead of the IF/ID register.
module ifetch_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH),
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   ir,
  output logic [XLEN-1:0]   npc,
  output logic              ir_valid,
  output logic              halted,
  output logic [1:0]        state
);

  localparam int unsigned INC_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [XLEN-1:0]   ir_q;
  logic [XLEN-1:0]   npc_q;
  logic              ir_valid_q;
  logic              halted_q;

  logic [XLEN-1:0]   mem_q [IMEM_DEPTH];

  logic [ADDR_W-1:0] fetch_addr_c;
  logic [ADDR_W:0]   fetch_inc_c;
  logic              halt_seen_c;
  logic              mem_we_c;
  logic              unused_redirect_hi;

  // Redirect target overrides the sequential PC; npc keeps the carry bit so
  // the last word reports IMEM_DEPTH rather than wrapping to zero.
  always_comb begin
    fetch_addr_c = redirect ? redirect_pc[ADDR_W-1:0] : pc_q;
    fetch_inc_c  = {1'b0, fetch_addr_c} + INC_W'(1);
    halt_seen_c  = ir_valid_q && (ir_q[XLEN-1 -: 6] == HALT_OP);
    mem_we_c     = !rst && (state_q == S_LOAD) && prog_we;
  end

  assign unused_redirect_hi = ^redirect_pc[XLEN-1:ADDR_W];

  // Program memory: host writes only in LOAD; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Fetch FSM: mode sequencing, PC advance, fetch register and halt status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      npc_q      <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!mode) begin
            state_q <= S_LOAD;
          end else if (start) begin
            state_q <= S_RUN;
            pc_q    <= '0;
          end
        end
        S_LOAD: begin
          if (mode && start) begin
            state_q <= S_RUN;
            pc_q    <= '0;
          end
        end
        S_RUN: begin
          if (halt_seen_c) begin
            // halt word already presented once; it beats stall and redirect
            state_q    <= S_HALT;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end else if (redirect || !stall) begin
            ir_q       <= mem_q[fetch_addr_c];
            npc_q      <= XLEN'(fetch_inc_c);
            pc_q       <= fetch_inc_c[ADDR_W-1:0];
            ir_valid_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (!mode) begin
            state_q  <= S_LOAD;
            halted_q <= 1'b0;
          end else if (start) begin
            state_q  <= S_RUN;
            pc_q     <= '0;
            halted_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ir       = ir_q;
  assign npc      = npc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: table of per-cycle vectors plus a wrap-around run.
module tb_ifetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] H     = 32'hFC00_0000;

  logic            clk = 1'b0;
  logic            rst, mode, start, prog_we, stall, redirect;
  logic [AW-1:0]   prog_addr;
  logic [XLEN-1:0] prog_data, redirect_pc;
  logic [XLEN-1:0] ir, npc;
  logic            ir_valid, halted;
  logic [1:0]      state;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .HALT_OP(6'b111111)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir(ir), .npc(npc), .ir_valid(ir_valid), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, mode, start, we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall, redir;
    logic [31:0] rpc;
    logic [31:0] ir, npc;
    logic        v, h;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic s, input logic we,
                     input logic [4:0] a, input logic [31:0] d, input logic st_i,
                     input logic rd, input logic [31:0] rp, input logic [31:0] e_ir,
                     input logic [31:0] e_npc, input logic e_v, input logic e_h,
                     input logic [1:0] e_st);
    vec_t t;
    t.rst = r; t.mode = m; t.start = s; t.we = we; t.addr = a; t.data = d;
    t.stall = st_i; t.redir = rd; t.rpc = rp;
    t.ir = e_ir; t.npc = e_npc; t.v = e_v; t.h = e_h; t.st = e_st;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; mode = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //  rst m s we addr data         stl rd rpc            ir          npc v h st
    add(1, 0, 0, 0, 0,  0,            0, 0, 0,             0,          0,  0, 0, 2'd0); // 0 reset
    add(0, 0, 0, 0, 0,  0,            0, 0, 0,             0,          0,  0, 0, 2'd1); // 1 IDLE->LOAD
    add(0, 0, 0, 1, 0,  32'h1,        0, 0, 0,             0,          0,  0, 0, 2'd1);
    add(0, 0, 0, 1, 1,  32'h2,        0, 0, 0,             0,          0,  0, 0, 2'd1);
    add(0, 0, 0, 1, 2,  32'h3,        0, 0, 0,             0,          0,  0, 0, 2'd1);
    add(0, 0, 0, 1, 3,  H,            0, 0, 0,             0,          0,  0, 0, 2'd1);
    add(0, 1, 1, 0, 0,  0,            0, 0, 0,             0,          0,  0, 0, 2'd2); // 6 start
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h1,      1,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h3,      3,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  0, 1, 2'd3); // 11 HALT
    add(0, 1, 0, 0, 0,  0,            1, 1, 8,             H,          4,  0, 1, 2'd3); // 12 ignored
    add(0, 1, 1, 0, 0,  0,            0, 0, 0,             H,          4,  0, 0, 2'd2); // 13 restart
    add(0, 0, 0, 0, 0,  0,            0, 0, 0,             32'h1,      1,  1, 0, 2'd2); // mode ignored
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h3,      3,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  0, 1, 2'd3);
    add(0, 0, 0, 0, 0,  0,            0, 0, 0,             H,          4,  0, 0, 2'd1); // 19 HALT->LOAD
    add(0, 0, 0, 1, 16, 32'hAAA,      0, 0, 0,             H,          4,  0, 0, 2'd1);
    add(0, 0, 0, 1, 17, H,            0, 0, 0,             H,          4,  0, 0, 2'd1);
    add(0, 1, 1, 0, 0,  0,            0, 0, 0,             H,          4,  0, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h1,      1,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h2,      2,  1, 0, 2'd2); // pc=2
    add(0, 1, 0, 0, 0,  0,            1, 0, 0,             32'h2,      2,  1, 0, 2'd2); // stall x3
    add(0, 1, 0, 0, 0,  0,            1, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            1, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            1, 1, 32'hFFFF_FF10, 32'hAAA,    17, 1, 0, 2'd2); // redirect wins
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          18, 1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 1, 0,             H,          18, 0, 1, 2'd3); // halt beats redirect
    add(0, 0, 0, 0, 0,  0,            0, 0, 0,             H,          18, 0, 0, 2'd1);
    add(0, 1, 1, 0, 0,  0,            0, 0, 0,             H,          18, 0, 0, 2'd2);
    add(0, 1, 0, 1, 0,  32'hDEADBEEF, 0, 0, 0,             32'h1,      1,  1, 0, 2'd2); // we in RUN
    add(0, 1, 0, 1, 1,  32'h0,        0, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(1, 1, 1, 1, 2,  32'h12345678, 0, 0, 0,             0,          0,  0, 0, 2'd0); // reset wins
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             0,          0,  0, 0, 2'd0); // IDLE holds
    add(0, 1, 1, 0, 0,  0,            0, 0, 0,             0,          0,  0, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h1,      1,  1, 0, 2'd2); // mem intact
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h2,      2,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             32'h3,      3,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  1, 0, 2'd2);
    add(0, 1, 0, 0, 0,  0,            0, 0, 0,             H,          4,  0, 1, 2'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; mode = vecs[i].mode; start = vecs[i].start;
      prog_we = vecs[i].we; prog_addr = vecs[i].addr; prog_data = vecs[i].data;
      stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      cycle();
      chk($sformatf("v%0d ir", i),       ir,                vecs[i].ir);
      chk($sformatf("v%0d npc", i),      npc,               vecs[i].npc);
      chk($sformatf("v%0d ir_valid", i), 32'(ir_valid),     32'(vecs[i].v));
      chk($sformatf("v%0d halted", i),   32'(halted),       32'(vecs[i].h));
      chk($sformatf("v%0d state", i),    32'(state),        32'(vecs[i].st));
    end

    // Wrap-around: fill memory with non-halt words and run past the last address.
    idle_inputs();
    mode = 1'b0;
    cycle();
    chk("wrap load state", 32'(state), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = 32'h100 + 32'(i);
      cycle();
    end
    prog_we = 1'b0; mode = 1'b1; start = 1'b1;
    cycle();
    chk("wrap run state", 32'(state), 32'd2);
    start = 1'b0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle();
      chk($sformatf("wrap%0d ir", k),    ir,            32'h100 + 32'(k % DEPTH));
      chk($sformatf("wrap%0d npc", k),   npc,           32'(k % DEPTH) + 32'd1);
      chk($sformatf("wrap%0d valid", k), 32'(ir_valid), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Parametrised successor to the pipeline's fetch stage.
- Owns an XLEN-wide, IMEM_DEPTH-deep instruction memory with two modes:
  - code mode: host writes the program.
  - execute mode: PC fetches, wraps and repeats until a HALT opcode is fetched.
- Adds stall, branch redirect, fetch-valid and halt status. The plain fetch stage has none of these.
- Sits in front of the IF/ID pipeline register; redirect comes from the execute stage.

Parameters:
XLEN, 32, instruction/data width in bits
IMEM_DEPTH, 1024, instruction memory depth in words (power of two)
ADDR_W, 10, log2(IMEM_DEPTH); PC width
HALT_OP, 6'b111111, opcode in IR[XLEN-1:XLEN-6] that halts execution

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
mode  input  1  0 = code (load) mode, 1 = execute mode
start  input  1  single-cycle pulse; begins execution from PC 0
prog_we  input  1  program write enable (honoured in LOAD only)
prog_addr  input  ADDR_W  program write word address
prog_data  input  XLEN  program write data
stall  input  1  hold fetch outputs and PC this cycle
redirect  input  1  branch taken (sel from execute)
redirect_pc  input  XLEN  branch target word address; low ADDR_W bits used
ir  output  XLEN  fetched instruction
npc  output  XLEN  address of fetched instruction + 1, zero-extended
ir_valid  output  1  ir/npc hold a real fetch this cycle
halted  output  1  HALT_OP fetched, unit idle
state  output  2  00 IDLE, 01 LOAD, 10 RUN, 11 HALT

Behaviour:
- Reset, applied synchronously in any state:
  - pc = 0, ir = 0, npc = 0, ir_valid = 0, halted = 0, state = IDLE.
  - Instruction memory is NOT cleared.
- Addressing is word-addressed; PC increments by 1 modulo IMEM_DEPTH.
- IDLE:
  - mode=0 -> LOAD.
  - mode=1 and start -> RUN, with pc = 0.
- LOAD:
  - prog_we=1 writes mem[prog_addr] <= prog_data at the edge.
  - start with mode=1 -> RUN, pc = 0. A write in that same cycle still commits.
  - prog_we is ignored in every other state.
- RUN, each cycle:
  - fetch_addr = redirect ? redirect_pc[ADDR_W-1:0] : pc.
  - Redirect takes priority over stall (branch flush wins).
  - If not stalled, or redirect=1: ir <= mem[fetch_addr], npc <= fetch_addr+1, pc <= (fetch_addr+1) mod IMEM_DEPTH, ir_valid <= 1.
  - Latency: ir is valid one cycle after its address is presented.
  - stall=1 and redirect=0: pc, ir, npc, ir_valid hold.
  - Wrap: pc = IMEM_DEPTH-1 fetches, then pc = 0. npc reports IMEM_DEPTH, i.e. the unwrapped +1 value.
  - mode and start are ignored.
- Halt:
  - When the word just latched into ir has opcode HALT_OP, ir_valid=1 stays for that cycle and state goes to HALT next edge.
  - In HALT: ir_valid=0, halted=1, pc frozen, ir holds the halt word. stall/redirect are ignored.
- HALT exits:
  - start with mode=1 -> RUN, pc = 0, halted = 0.
  - mode=0 -> LOAD, halted = 0.
- Simultaneous events:
  - A redirect in the cycle the halt word is in ir is ignored (HALT wins).
  - A reset asserted together with start/prog_we wins; no write occurs.

Test Plan:
- Reset -> state=00, ir=0, npc=0, ir_valid=0, halted=0.
- Load program, then run:
  - Stimulus: mode=0; write mem[0..3]=0x00000001, 0x00000002, 0x00000003, 0xFC000000; mode=1, start.
  - Response: ir=1, 2, 3, 0xFC000000 on consecutive cycles; npc=1, 2, 3, 4; then halted=1, ir_valid=0, state=11.
- Stall and redirect:
  - Stimulus: in RUN at pc=2, assert stall 3 cycles.
  - Response: ir/npc frozen 3 cycles.
  - Stimulus: stall=1 with redirect=1, redirect_pc=0x10.
  - Response: next ir=mem[16], npc=17.
- Wrap-around: IMEM_DEPTH=8, no HALT word present -> after ir=mem[7] (npc=8), next ir=mem[0], npc=1; runs continuously.
- Restart after halt: in HALT, pulse start (mode=1) -> ir=mem[0] next cycle, ir_valid=1, halted=0. Separately, mode=0 in HALT -> state=01.
- Reset mid-run: rst during RUN at pc=5 -> all outputs reset next edge. Restart -> mem[0..3] unchanged; prog_we pulses issued during RUN had no effect.
